led_ctrl: RTL and testbench
===========================

Name: led_ctrl

Overview:
- Parametrised N-channel LED driver; successor to the single-channel fixed-rate blinker.
- Per channel, selects one of four modes: OFF, ON, BLINK at a programmable half-period, or BREATHE (triangle-ramped PWM).
- Channels are configured at run time through a valid/ready write port.
- Sits between board-level control logic (buttons, UART command decoder) and the LED pins.

Parameters:
- CLK_HZ, 27000000, sys_clk frequency in Hz.
- TICK_HZ, 1000, timebase tick rate. 1 tick = 1 ms at default. Tick prescaler divisor = CLK_HZ/TICK_HZ; must be ≥2.
- N_LED, 4, number of LED channels (1..16).
- PWM_BITS, 8, PWM/duty resolution in bits.
- DEFAULT_HALF_MS, 500, half-period in ticks loaded into every channel at reset.
- ACTIVE_LOW, 1, 1 = LED lit when pin is 0.

Ports:
- sys_clk, input, 1, system clock.
- sys_rst_n, input, 1, reset.
- cfg_valid, input, 1, config write request.
- cfg_ready, output, 1, config port can accept.
- cfg_ch, input, 4, target channel index.
- cfg_mode, input, 2, mode encoding: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- cfg_half_ms, input, 16, half-period / ramp-step interval in ticks.
- led, output, N_LED, LED pins; polarity per ACTIVE_LOW.
- tick, output, 1, one-cycle timebase strobe (debug/observability).

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. All logic posedge sys_clk; async clear on negedge sys_rst_n.
- Reset values:
  - led = all inactive (all 1s when ACTIVE_LOW=1).
  - tick = 0, cfg_ready = 0.
  - Every channel: mode = BLINK, half = DEFAULT_HALF_MS, cnt = 0, phase = unlit, duty = 0, dir = up.
  - Prescaler = 0, PWM counter = 0.
- cfg_ready: 1 from the first clock after reset release; stays 1 thereafter.
- Timebase:
  - Prescaler counts 0..CLK_HZ/TICK_HZ-1 then wraps to 0.
  - tick = 1 for exactly the cycle in which the prescaler equals CLK_HZ/TICK_HZ-1.
- PWM counter: free-running PWM_BITS counter, shared by all channels, wraps naturally.
- Config accept (cfg_valid & cfg_ready on a rising edge):
  - If cfg_ch < N_LED: the channel's mode and half are written; cnt = 0, phase = lit, duty = 0, dir = up.
  - If cfg_ch ≥ N_LED: the write is accepted and discarded; no state changes.
  - cfg_half_ms = 0 is stored as 1.
  - A write takes priority over any tick-driven update of the same channel in the same cycle.
- Per-channel update on tick (not overridden by a same-cycle write):
  - If cnt == half-1: cnt = 0 and an event fires. Otherwise cnt = cnt + 1.
  - BLINK event: phase toggles.
  - BREATHE event, dir up: duty+1; if duty was already max (2^PWM_BITS-1), dir = down and duty holds.
  - BREATHE event, dir down: duty-1; if duty was already 0, dir = up and duty holds.
  - OFF/ON: counters run, outputs unaffected.
- Lit function, per channel:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase.
  - BREATHE: (pwm_cnt < duty). duty = 0 gives never lit; max gives lit 255/256 of cycles.
- Output: led[i] is registered; led[i] = lit XOR ACTIVE_LOW.
- Latency:
  - Config write → led change: 1 cycle after the accept edge.
  - BLINK toggle visible 1 cycle after the event tick.
- Channels are fully independent. Differing half values must not interact.
- Reset mid-operation: all state returns immediately to reset values, including an in-flight write.

Optional Feature:
- Macro: LED_CTRL_BREATHE_EN.
- Defined: BREATHE mode as above; duty/dir registers and PWM counter are present.
- Undefined: no duty/dir/PWM logic is built. Mode 3 behaves identically to BLINK. Writes with mode 3 are still accepted.

Test Plan (CLK_HZ=10000, TICK_HZ=1000 → tick every 10 cycles; N_LED=4; DEFAULT_HALF_MS=5):
- Reset test:
  - Stimulus: hold reset 3 cycles, release, no writes.
  - Required: led = 4'b1111; cfg_ready rises 1 cycle after release.
  - Required: every channel toggles together every 50 cycles, first toggle at tick 5 (led = 4'b0000).
- Static modes:
  - Stimulus: write ch1 mode=ON, then ch2 mode=OFF.
  - Required: led[1] = 0 exactly 1 cycle after the accept and stays 0; led[2] = 1 permanently.
  - Required: ch0 and ch3 keep blinking undisturbed.
- Half-period edge cases:
  - Stimulus: write ch3 BLINK with half=0.
  - Required: behaves as half=1; led[3] toggles every 10 cycles, lit immediately after the write.
- Write/tick collision:
  - Stimulus: write ch0 BLINK half=2 in the same cycle tick=1 while ch0 cnt==half-1.
  - Required: the write wins; cnt = 0, phase = lit; next toggle comes 2 ticks later.
- Out-of-range channel:
  - Stimulus: write with cfg_ch=7, mode=ON.
  - Required: accepted (ready=1); no led bit or channel state changes.
- BREATHE (macro defined, PWM_BITS=4):
  - Stimulus: ch0 BREATHE, half=1.
  - Required: duty ramps 0→15 over 15 ticks, holds one tick, ramps down, holds at 0.
  - Required: lit count per 16-cycle PWM window equals duty.
  - Macro undefined: same write yields the BLINK waveform.

Source files
------------

// File: rtl/led_ctrl.sv
// N-channel LED driver: OFF / ON / BLINK / BREATHE per channel, configured via a valid/ready write port.
// Define LED_CTRL_BREATHE_EN to build the triangle-ramped PWM (BREATHE) datapath; otherwise mode 3 blinks.
module led_ctrl #(
    parameter int CLK_HZ          = 27000000,
    parameter int TICK_HZ         = 1000,
    parameter int N_LED           = 4,
    parameter int PWM_BITS        = 8,
    parameter int DEFAULT_HALF_MS = 500,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [15:0]      cfg_half_ms,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam int   DIV   = CLK_HZ / TICK_HZ;
    localparam int   PW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);
    localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;

    logic [PW-1:0]    presc;
    logic             accept;
    logic [N_LED-1:0] lit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc     <= '0;
            cfg_ready <= 1'b0;
        end else begin
            presc     <= (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;
            cfg_ready <= 1'b1;
        end
    end

    assign tick   = (presc == PW'(DIV - 1));
    assign accept = cfg_valid & cfg_ready;

`ifdef LED_CTRL_BREATHE_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pwm_cnt <= '0;
        else            pwm_cnt <= pwm_cnt + 1'b1;
    end
`endif

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        logic [1:0]  mode;
        logic [15:0] half;
        logic [15:0] cnt;
        logic        phase;
        logic        wr;
        logic        event_hit;
        logic        toggles;

        // Out-of-range channel indices simply never match any channel.
        assign wr        = accept && (cfg_ch == 4'(i));
        assign event_hit = tick && (cnt == half - 16'd1);
`ifdef LED_CTRL_BREATHE_EN
        assign toggles   = (mode == M_BLINK);
`else
        assign toggles   = mode[1];
`endif

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                mode  <= M_BLINK;
                half  <= 16'(DEFAULT_HALF_MS);
                cnt   <= '0;
                phase <= 1'b0;
            end else if (wr) begin
                mode  <= cfg_mode;
                half  <= (cfg_half_ms == 16'd0) ? 16'd1 : cfg_half_ms;
                cnt   <= '0;
                phase <= 1'b1;
            end else if (tick) begin
                cnt <= event_hit ? 16'd0 : cnt + 16'd1;
                if (event_hit && toggles) phase <= ~phase;
            end
        end

`ifdef LED_CTRL_BREATHE_EN
        logic [PWM_BITS-1:0] duty;
        logic                dir_down;

        // Endpoints hold for one event while the direction flips.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                duty     <= '0;
                dir_down <= 1'b0;
            end else if (wr) begin
                duty     <= '0;
                dir_down <= 1'b0;
            end else if (event_hit && mode == M_BREATHE) begin
                if (!dir_down) begin
                    if (duty == DUTY_MAX) dir_down <= 1'b1;
                    else                  duty     <= duty + 1'b1;
                end else begin
                    if (duty == '0) dir_down <= 1'b0;
                    else            duty     <= duty - 1'b1;
                end
            end
        end
`endif

        always_comb begin
            lit[i] = 1'b0;
            case (mode)
                M_OFF:     lit[i] = 1'b0;
                M_ON:      lit[i] = 1'b1;
                M_BLINK:   lit[i] = phase;
`ifdef LED_CTRL_BREATHE_EN
                M_BREATHE: lit[i] = (pwm_cnt < duty);
`else
                M_BREATHE: lit[i] = phase;
`endif
                default:   lit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) led <= {N_LED{POL}};
        else            led <= lit ^ {N_LED{POL}};
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: a tick/event-count reference model predicts each cycle's outputs.
module tb_led_ctrl;
    localparam int CLK_HZ   = 10000;
    localparam int TICK_HZ  = 1000;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int N_LED    = 4;
    localparam int DEF_HALF = 5;
`ifdef LED_CTRL_BREATHE_EN
    localparam int PWM_BITS = 4;
`else
    localparam int PWM_BITS = 8;
`endif
    localparam int PWM_MAX  = (1 << PWM_BITS) - 1;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [1:0]       cfg_mode;
    logic [15:0]      cfg_half_ms;
    logic [N_LED-1:0] led;
    logic             tick;

    led_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_LED(N_LED), .PWM_BITS(PWM_BITS),
        .DEFAULT_HALF_MS(DEF_HALF), .ACTIVE_LOW(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half_ms(cfg_half_ms), .led(led), .tick(tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [N_LED-1:0] led;
        logic             tk;
        logic             rdy;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   n;

    int m_mode [N_LED];
    int m_half [N_LED];
    int m_t    [N_LED];
    bit m_init [N_LED];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", nm, n, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_LED; i++) begin
            m_mode[i] = 2;
            m_half[i] = DEF_HALF;
            m_t[i]    = 0;
            m_init[i] = 1'b0;
        end
    endtask

    // Lit state from the number of events since the last write: k = ticks / half.
    function automatic bit model_lit(input int i, input int pwm);
        int k;
        int m;
        int duty;
        bit ph;
        k    = m_t[i] / m_half[i];
        m    = k % (2 * (PWM_MAX + 1));
        duty = (m <= PWM_MAX) ? m : (2 * PWM_MAX + 1 - m);
        ph   = m_init[i] ^ k[0];
        case (m_mode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ph;
`ifdef LED_CTRL_BREATHE_EN
            default: return (pwm < duty);
`else
            default: return ph;
`endif
        endcase
    endfunction

    task automatic cycle(input bit v, input int ch, input int mode, input int half);
        exp_t e;
        bit   acc;
        bit   tk_edge;
        cfg_valid   = v;
        cfg_ch      = ch[3:0];
        cfg_mode    = mode[1:0];
        cfg_half_ms = half[15:0];
        @(posedge sys_clk);
        n++;
        #2;
        if (n == 1) chk("ready_rise", {31'd0, cfg_ready}, 32'd1);
        tk_edge = (n % DIV == 0);
        acc     = v && (n >= 2);
        for (int i = 0; i < N_LED; i++) begin
            if (acc && ch == i) begin
                m_mode[i] = mode;
                m_half[i] = (half == 0) ? 1 : half;
                m_t[i]    = 0;
                m_init[i] = 1'b1;
            end else if (tk_edge) begin
                m_t[i]++;
            end
        end
        for (int i = 0; i < N_LED; i++) e.led[i] = ~model_lit(i, n % (PWM_MAX + 1));
        e.tk  = ((n + 1) % DIV == DIV - 1);
        e.rdy = 1'b1;
        q.push_back(e);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) cycle(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        cfg_valid = 1'b0;
        q.delete();
        model_reset();
        #1;
        chk("async_rst_led", {28'd0, led}, {28'd0, {N_LED{1'b1}}});
        repeat (cycles) @(negedge sys_clk);
        chk("rst_led", {28'd0, led}, {28'd0, {N_LED{1'b1}}});
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        sys_rst_n = 1'b1;
        n = 0;
    endtask

    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (sys_rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("led", {28'd0, led}, {28'd0, e.led});
            chk("tick", {31'd0, tick}, {31'd0, e.tk});
            chk("ready", {31'd0, cfg_ready}, {31'd0, e.rdy});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at edge %0d: actual=running required=finished", n);
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        n           = 0;
        sys_rst_n   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_ch      = '0;
        cfg_mode    = '0;
        cfg_half_ms = '0;
        model_reset();

        do_reset(3);
        idle(49);
        cycle(1'b1, 0, 2, 2);         // lands on the tick where ch0 would fire
        idle(60);
        cycle(1'b1, 1, 1, 7);
        cycle(1'b1, 2, 0, 9);
        idle(30);
        cycle(1'b1, 3, 2, 0);
        idle(40);
        cycle(1'b1, 7, 1, 3);
        idle(60);
        cycle(1'b1, 0, 3, 1);
        idle(2 * (PWM_MAX + 1) * DIV + 200);

        do_reset(2);
        idle(30);
        for (int r = 0; r < 3000; r++) begin
            if ($urandom_range(0, 7) == 0)
                cycle(1'b1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4));
            else
                idle(1);
        end

        @(posedge sys_clk);
        #3;
        if (q.size() != 0) chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
